// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encodings, access-size constants and lane helpers for the buffered LSU
package lsu_pkg;
    typedef enum logic [2:0] {IDLE, LD_REQ, LD_WAIT, LD_DROP, ST_REQ} state_e;
    localparam logic [3:0] SEL_BYTE = 4'b0001;
    localparam logic [3:0] SEL_HALF = 4'b0011;
    localparam logic [3:0] SEL_WORD = 4'b1111;
    typedef struct packed {
        logic [3:0]  we;
        logic [31:0] data;
    } sb_payload_t;
    function automatic logic misaligned(input logic [3:0] sel, input logic [1:0] off);
        return (sel == SEL_HALF && off[0]) || (sel == SEL_WORD && off != 2'b00);
    endfunction
    function automatic logic [3:0] strobe(input logic [3:0] sel, input logic [1:0] off);
        return sel == SEL_WORD ? 4'b1111 : sel == SEL_HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b0001 << off;
    endfunction
    function automatic logic [31:0] extract(input logic [31:0] rdata, input logic [3:0] sel,
                                            input logic [1:0] off, input logic sext);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(rdata >> {off, 3'b000});
        h = off[1] ? rdata[31:16] : rdata[15:0];
        return sel == SEL_BYTE ? {{24{sext & b[7]}}, b} : sel == SEL_HALF ? {{16{sext & h[15]}}, h} : rdata;
    endfunction
endpackage

// File: rtl/lsu_store_fifo.sv
// lsu_store_fifo: synchronous store-buffer FIFO with a parallel word-address match over valid entries
module lsu_store_fifo
    import lsu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1,
    parameter int AW    = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [AW-1:0]    push_addr,
    input  logic [3:0]       push_we,
    input  logic [31:0]      push_data,
    input  logic [AW-1:0]    cmp_addr,
    output logic [AW-1:0]    head_addr,
    output logic [3:0]       head_we,
    output logic [31:0]      head_data,
    output logic             hit,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    logic [AW-1:0]    addr_q [DEPTH];
    logic [AW-1:0]    addr_d [DEPTH];
    sb_payload_t      pay_q  [DEPTH];
    sb_payload_t      pay_d  [DEPTH];
    logic [PW-1:0]    rel    [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    always_comb begin
        addr_d = addr_q;
        pay_d = pay_q;
        if (push) begin
            addr_d[wptr_q] = push_addr;
            pay_d[wptr_q] = '{we: push_we, data: push_data};
        end
        wptr_d = wptr_q + PW'(push);
        rptr_d = rptr_q + PW'(pop);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rel[i] = PW'(i) - rptr_q;
            hit = hit | ({1'b0, rel[i]} < count_q && addr_q[i] == cmp_addr);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            count_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            count_q <= count_d;
            addr_q <= addr_d;
            pay_q <= pay_d;
        end
    end
    assign head_addr = addr_q[rptr_q];
    assign head_we = pay_q[rptr_q].we;
    assign head_data = pay_q[rptr_q].data;
    assign full = count_q == CNT_W'(DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;
endmodule

// File: rtl/lsu_buffered.sv
// lsu_buffered: memory-access stage with alignment traps, a posted store buffer and multi-cycle bus loads
module lsu_buffered
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int SB_DEPTH   = 4,
    parameter int SB_CNT_W   = $clog2(SB_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic                  req_sign_ext,
    input  logic [3:0]            req_sel,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic                  flush,
    output logic                  adel,
    output logic                  ades,
    output logic [ADDR_WIDTH-1:0] badvaddr,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic [SB_CNT_W-1:0]   sb_count,
    output logic                  sb_empty,
    output logic                  bus_req,
    output logic [3:0]            bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [31:0]           bus_wdata,
    input  logic                  bus_gnt,
    input  logic                  bus_rvalid,
    input  logic [31:0]           bus_rdata
);
    localparam int WA = ADDR_WIDTH - 2;
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ld_addr_q, ld_addr_d;
    logic [3:0]            ld_sel_q, ld_sel_d;
    logic                  ld_sext_q, ld_sext_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    logic                  mis, full, empty, hit, st_accept, ld_accept, pop;
    logic [WA-1:0]         head_addr;
    logic [3:0]            head_we;
    logic [31:0]           head_data;
    assign mis = misaligned(req_sel, req_addr[1:0]);
    assign adel = req_valid & req_read & mis;
    assign ades = req_valid & req_write & mis;
    assign badvaddr = (adel | ades) ? req_addr : '0;
    assign st_accept = req_valid & req_write & ~mis & ~full & (state_q == IDLE || state_q == ST_REQ);
    assign ld_accept = req_valid & req_read & ~mis & ~hit & (state_q == IDLE);
    assign req_ready = adel | ades | st_accept | ld_accept;
    assign pop = (state_q == ST_REQ) & bus_gnt;
    lsu_store_fifo #(.DEPTH(SB_DEPTH), .CNT_W(SB_CNT_W), .AW(WA)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (st_accept),
        .pop       (pop),
        .push_addr (req_addr[ADDR_WIDTH-1:2]),
        .push_we   (strobe(req_sel, req_addr[1:0])),
        .push_data (req_wdata << {req_addr[1:0], 3'b000}),
        .cmp_addr  (req_addr[ADDR_WIDTH-1:2]),
        .head_addr (head_addr),
        .head_we   (head_we),
        .head_data (head_data),
        .hit       (hit),
        .full      (full),
        .empty     (empty),
        .count     (sb_count)
    );
    always_comb begin
        state_d = state_q;
        ld_addr_d = ld_addr_q;
        ld_sel_d = ld_sel_q;
        ld_sext_d = ld_sext_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        case (state_q)
            IDLE: begin
                if (ld_accept) begin
                    state_d = LD_REQ;
                    ld_addr_d = req_addr;
                    ld_sel_d = req_sel;
                    ld_sext_d = req_sign_ext;
                end else if (!empty) begin
                    state_d = ST_REQ;
                end
            end
            // a grant that coincides with flush has already launched the read, so its data must be absorbed
            LD_REQ: state_d = bus_gnt ? (flush ? LD_DROP : LD_WAIT) : flush ? IDLE : LD_REQ;
            LD_WAIT: begin
                if (bus_rvalid) begin
                    state_d = IDLE;
                    resp_valid_d = ~flush;
                    resp_rdata_d = extract(bus_rdata, ld_sel_q, ld_addr_q[1:0], ld_sext_q);
                end else if (flush) begin
                    state_d = LD_DROP;
                end
            end
            LD_DROP: state_d = bus_rvalid ? IDLE : LD_DROP;
            ST_REQ: state_d = bus_gnt ? IDLE : ST_REQ;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ld_addr_q <= '0;
            ld_sel_q <= '0;
            ld_sext_q <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ld_addr_q <= ld_addr_d;
            ld_sel_q <= ld_sel_d;
            ld_sext_q <= ld_sext_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign sb_empty = empty;
    assign bus_req = state_q == LD_REQ || state_q == ST_REQ;
    assign bus_we = state_q == ST_REQ ? head_we : 4'b0000;
    assign bus_addr = state_q == ST_REQ ? {head_addr, 2'b00} :
                      state_q == LD_REQ ? {ld_addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign bus_wdata = state_q == ST_REQ ? head_data : '0;
endmodule

// File: tb/tb_lsu_buffered.sv
// tb_lsu_buffered: directed vectors with hand-computed expectations for lsu_buffered
module tb_lsu_buffered;
    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, req_read, req_write, req_sign_ext, flush;
    logic [3:0]  req_sel, bus_we;
    logic [31:0] req_addr, req_wdata, badvaddr, resp_rdata, bus_addr, bus_wdata, bus_rdata;
    logic        adel, ades, resp_valid, sb_empty, bus_req, bus_gnt, bus_rvalid;
    logic [2:0]  sb_count;
    int          n_chk = 0;
    int          n_fail = 0;
    int          k;
    lsu_buffered #(.ADDR_WIDTH(32), .SB_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read),
        .req_write(req_write), .req_sign_ext(req_sign_ext), .req_sel(req_sel), .req_addr(req_addr),
        .req_wdata(req_wdata), .flush(flush), .adel(adel), .ades(ades), .badvaddr(badvaddr),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .sb_count(sb_count), .sb_empty(sb_empty),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(negedge clk);
    endtask
    task automatic req(input logic rd, input logic wr, input logic sext, input logic [3:0] sel,
                       input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_read = rd;
        req_write = wr;
        req_sign_ext = sext;
        req_sel = sel;
        req_addr = addr;
        req_wdata = wdata;
    endtask
    task automatic idle();
        req_valid = 1'b0;
        req_read = 1'b0;
        req_write = 1'b0;
    endtask
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [3:0] sel,
                           input logic sext, input logic [31:0] rdata, input logic [31:0] exp);
        step(); req(1'b1, 1'b0, sext, sel, addr, 32'h0); #1;
        chk({tag, " ready"}, req_ready, 1);
        step(); idle(); bus_gnt = 1'b1; #1;
        chk({tag, " bus_req"}, bus_req, 1);
        chk({tag, " bus_we"}, bus_we, 0);
        chk({tag, " bus_addr"}, bus_addr, {addr[31:2], 2'b00});
        step(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = rdata; #1;
        chk({tag, " early resp"}, resp_valid, 0);
        step(); bus_rvalid = 1'b0; #1;
        chk({tag, " resp_valid"}, resp_valid, 1);
        chk({tag, " resp_rdata"}, resp_rdata, exp);
        step(); #1;
        chk({tag, " resp pulse"}, resp_valid, 0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        rst = 1'b1; flush = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        req_sign_ext = 1'b0; req_sel = '0; req_addr = '0; req_wdata = '0;
        idle();
        repeat (2) step();
        #1;
        chk("rst bus_req", bus_req, 0);
        chk("rst resp_valid", resp_valid, 0);
        chk("rst sb_count", sb_count, 0);
        chk("rst sb_empty", sb_empty, 1);
        step(); rst = 1'b0;
        step(); req(1'b0, 1'b1, 1'b0, 4'b0001, 32'h1003, 32'hA5); #1;
        chk("stb ready", req_ready, 1);
        step(); idle(); #1;
        chk("stb count", sb_count, 1);
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            chk("stb bus_req", bus_req, 1);
            chk("stb bus_we", bus_we, 4'b1000);
            chk("stb bus_addr", bus_addr, 32'h1000);
            chk("stb bus_wdata", bus_wdata, 32'hA500_0000);
            chk("stb hold count", sb_count, 1);
        end
        bus_gnt = 1'b1;
        step(); bus_gnt = 1'b0; #1;
        chk("stb drained", sb_count, 0);
        chk("stb bus idle", bus_req, 0);
        do_load("lh sext", 32'h2002, 4'b0011, 1'b1, 32'h80FF_1234, 32'hFFFF_80FF);
        do_load("lh zext", 32'h2002, 4'b0011, 1'b0, 32'h80FF_1234, 32'h0000_80FF);
        do_load("lb sext", 32'h5001, 4'b0001, 1'b1, 32'h1234_9678, 32'hFFFF_FF96);
        do_load("lb zext", 32'h5003, 4'b0001, 1'b0, 32'h8234_9678, 32'h0000_0082);
        do_load("lw", 32'h6000, 4'b1111, 1'b1, 32'h8765_4321, 32'h8765_4321);
        step(); req(1'b1, 1'b0, 1'b0, 4'b1111, 32'h3001, 32'h0); #1;
        chk("adel", adel, 1);
        chk("adel ades", ades, 0);
        chk("adel badvaddr", badvaddr, 32'h3001);
        chk("adel ready", req_ready, 1);
        chk("adel bus_req", bus_req, 0);
        step(); req(1'b0, 1'b1, 1'b0, 4'b1111, 32'h3002, 32'h0); #1;
        chk("ades word", ades, 1);
        chk("ades adel", adel, 0);
        chk("ades badvaddr", badvaddr, 32'h3002);
        step(); req(1'b0, 1'b1, 1'b0, 4'b0011, 32'h3003, 32'h0); #1;
        chk("ades half", ades, 1);
        step(); idle(); #1;
        chk("mis no enqueue", sb_count, 0);
        chk("mis no bus", bus_req, 0);
        chk("mis no resp", resp_valid, 0);
        chk("badvaddr clear", badvaddr, 0);
        for (int i = 0; i < 4; i++) begin
            step(); req(1'b0, 1'b1, 1'b0, 4'b1111, 32'h7000 + 32'(4 * i), 32'h1111_0000 + 32'(i)); #1;
            chk("fill ready", req_ready, 1);
        end
        step(); req(1'b0, 1'b1, 1'b0, 4'b1111, 32'h7010, 32'h1111_0004); #1;
        chk("full stall", req_ready, 0);
        chk("full count", sb_count, 4);
        repeat (2) begin
            step(); #1;
            chk("full stall", req_ready, 0);
            chk("full count", sb_count, 4);
            chk("full head", bus_addr, 32'h7000);
        end
        step(); bus_gnt = 1'b1; #1;
        chk("full gnt stall", req_ready, 0);
        step(); bus_gnt = 1'b0; #1;
        chk("after pop ready", req_ready, 1);
        chk("after pop count", sb_count, 3);
        step(); idle(); #1;
        chk("refill count", sb_count, 4);
        k = 0;
        for (int c = 0; c < 40 && k < 4; c++) begin
            if (bus_req) begin
                chk("drain addr", bus_addr, 32'h7004 + 32'(4 * k));
                chk("drain data", bus_wdata, 32'h1111_0001 + 32'(k));
                bus_gnt = 1'b1;
                k++;
            end else begin
                bus_gnt = 1'b0;
            end
            step(); #1;
        end
        bus_gnt = 1'b0;
        chk("drain count", 32'(k), 4);
        step(); #1;
        chk("drain empty", sb_empty, 1);
        step(); req(1'b0, 1'b1, 1'b0, 4'b1111, 32'h4000, 32'hDEAD_BEEF); #1;
        chk("haz st ready", req_ready, 1);
        step(); req(1'b1, 1'b0, 1'b0, 4'b0011, 32'h4002, 32'h0); #1;
        chk("haz idle stall", req_ready, 0);
        step(); #1;
        chk("haz st stall", req_ready, 0);
        chk("haz st bus_we", bus_we, 4'b1111);
        bus_gnt = 1'b1;
        step(); bus_gnt = 1'b0; #1;
        chk("haz ld ready", req_ready, 1);
        step(); idle(); #1;
        chk("haz ld bus_req", bus_req, 1);
        chk("haz ld bus_we", bus_we, 0);
        chk("haz ld bus_addr", bus_addr, 32'h4000);
        bus_gnt = 1'b1;
        step(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        step(); bus_rvalid = 1'b0; #1;
        chk("haz resp", resp_valid, 1);
        chk("haz rdata", resp_rdata, 32'h0000_DEAD);
        step(); req(1'b0, 1'b1, 1'b0, 4'b0001, 32'h8001, 32'h5A); #1;
        chk("prio st ready", req_ready, 1);
        step(); req(1'b1, 1'b0, 1'b0, 4'b1111, 32'h9000, 32'h0); #1;
        chk("prio ld ready", req_ready, 1);
        step(); idle(); #1;
        chk("prio ld bus_we", bus_we, 0);
        chk("prio ld addr", bus_addr, 32'h9000);
        bus_gnt = 1'b1;
        step(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
        step(); bus_rvalid = 1'b0; #1;
        chk("prio resp", resp_rdata, 32'hCAFE_F00D);
        step(); #1;
        chk("prio st bus_we", bus_we, 4'b0010);
        chk("prio st addr", bus_addr, 32'h8000);
        chk("prio st data", bus_wdata, 32'h0000_5A00);
        bus_gnt = 1'b1;
        step(); bus_gnt = 1'b0; #1;
        chk("prio empty", sb_empty, 1);
        step(); req(1'b1, 1'b0, 1'b0, 4'b1111, 32'hA000, 32'h0); #1;
        chk("fl ready", req_ready, 1);
        step(); idle(); bus_gnt = 1'b1;
        step(); bus_gnt = 1'b0; flush = 1'b1;
        step(); flush = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678; #1;
        chk("fl drop wait", resp_valid, 0);
        step(); bus_rvalid = 1'b0; #1;
        chk("fl suppressed", resp_valid, 0);
        step(); req(1'b1, 1'b0, 1'b0, 4'b1111, 32'hA004, 32'h0);
        step(); idle(); flush = 1'b1; #1;
        chk("fl ldreq bus_req", bus_req, 1);
        step(); flush = 1'b0; #1;
        chk("fl ldreq dropped", bus_req, 0);
        do_load("post flush", 32'hB000, 4'b1111, 1'b0, 32'h0123_4567, 32'h0123_4567);
        step(); req(1'b0, 1'b1, 1'b0, 4'b0011, 32'hC002, 32'h1234);
        step(); idle();
        step(); #1;
        chk("rst st bus_req", bus_req, 1);
        chk("rst st bus_we", bus_we, 4'b1100);
        chk("rst st data", bus_wdata, 32'h1234_0000);
        rst = 1'b1;
        step(); #1;
        chk("mid rst bus_req", bus_req, 0);
        chk("mid rst count", sb_count, 0);
        rst = 1'b0;
        step(); #1;
        chk("mid rst discard", bus_req, 0);
        chk("mid rst empty", sb_empty, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lsu_buffered.md
Name: lsu_buffered

Overview:
- Parametrised successor to the combinational memory-access stage.
- Accepts one load/store per handshake from the MEM pipeline slot.
- Checks alignment and raises AdEL/AdES, posts aligned stores into a store buffer, and runs loads as multi-cycle bus transactions.
- Drives a request/grant/rvalid data bus and returns sign/zero-extended load data to WB.

Parameters:
- ADDR_WIDTH, 32, address width; low 2 bits are the byte offset.
- SB_DEPTH, 4, store-buffer entries; power of two, at least 2.
- SB_CNT_W, $clog2(SB_DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  MEM slot holds a memory op.
- req_ready  out  1  op accepted this cycle; low means stall the pipeline.
- req_read  in  1  load.
- req_write  in  1  store; never high together with req_read.
- req_sign_ext  in  1  sign-extend load data.
- req_sel  in  4  0001 byte, 0011 half, 1111 word.
- req_addr  in  ADDR_WIDTH  effective address.
- req_wdata  in  32  store data, right-aligned.
- flush  in  1  exception/ERET flush from CP0.
- adel  out  1  misaligned load, combinational, valid while req_valid.
- ades  out  1  misaligned store, combinational.
- badvaddr  out  ADDR_WIDTH  req_addr when adel or ades is high, else 0.
- resp_valid  out  1  one-cycle pulse, load data ready.
- resp_rdata  out  32  extended load data.
- sb_count  out  SB_CNT_W  valid store-buffer entries.
- sb_empty  out  1  sb_count==0; used by SYNC and uncached ops.
- bus_req  out  1  bus request.
- bus_we  out  4  byte write strobes; 0 for a read.
- bus_addr  out  ADDR_WIDTH  word address, low 2 bits 0.
- bus_wdata  out  32  lane-shifted write data.
- bus_gnt  in  1  request accepted this cycle.
- bus_rvalid  in  1  read data valid; never in the same cycle as its gnt.
- bus_rdata  in  32  read word.

Behaviour:
- Reset (rst=1 at a clk edge), from any state including mid-transaction:
  - state=IDLE, FIFO pointers and count cleared.
  - All registered outputs 0; resp_valid=0, bus_req=0.
  - Buffered stores are discarded.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0.
  - Raise adel (read) or ades (write) and set badvaddr=req_addr.
  - req_ready=1; no bus traffic, no enqueue, no response.
- States: IDLE, LD_REQ, LD_WAIT, LD_DROP, ST_REQ.
- Aligned store:
  - Accepted when the FIFO is not full and state is IDLE or ST_REQ.
  - Enqueues {word addr, strobe, data << 8*offset}.
  - Byte strobes 0001/0010/0100/1000 by offset; half 0011/1100; word 1111.
  - Accepted in 1 cycle. A store accepted on a full FIFO is a stall (req_ready=0).
  - An enqueue and a pop in the same cycle leave sb_count unchanged.
- Aligned load:
  - Accepted only in IDLE and with no hazard. Hazard: any valid FIFO entry has the same addr[ADDR_WIDTH-1:2].
  - On accept, register addr, sel and sign_ext, then go to LD_REQ.
  - A load-accept in IDLE takes priority over starting a drain.
- IDLE with no load accepted and FIFO not empty: go to ST_REQ.
- ST_REQ:
  - bus_req=1 with the FIFO head on bus_we/bus_addr/bus_wdata, held stable until gnt.
  - On gnt: pop, go to IDLE.
- LD_REQ:
  - bus_req=1, bus_we=0, bus_addr=registered word address, held until gnt.
  - On gnt: go to LD_WAIT.
  - flush before gnt: drop bus_req, go to IDLE.
- LD_WAIT:
  - On rvalid: resp_valid=1 next cycle with extracted data, go to IDLE.
  - flush: go to LD_DROP.
- LD_DROP: wait for rvalid, suppress resp_valid, go to IDLE.
- Load extraction:
  - Select the byte/half by registered offset.
  - Bit 7 or bit 15 is replicated when sign_ext=1, else zero-filled. Word passes through.
- Flush does not affect FIFO contents; buffered stores are committed.
- Minimum load latency: accept at cycle 0, gnt at 1, rvalid at 2, resp_valid at 3.
- FIFO pointers wrap modulo SB_DEPTH. full = (count==SB_DEPTH).

Decomposition:
- Package lsu_pkg holds:
  - state encodings;
  - SEL_BYTE/SEL_HALF/SEL_WORD constants;
  - a struct/width constant for a store-buffer entry (addr, strobe, data).
- Sub-module lsu_store_fifo (synchronous FIFO) with:
  - push/pop, full/empty, count;
  - parallel address-compare output for the hazard check.

Test Plan:
- Store byte 0xA5 to 0x1003, gnt held low 3 cycles -> sb_count=1; bus_we=1000, bus_addr=0x1000, bus_wdata=0xA5000000 stable until gnt; sb_count=0 after.
- Load half, sign_ext, addr 0x2002, bus_rdata=0x80FF1234 -> resp_valid at cycle 3 with 0xFFFF80FF; same with sign_ext=0 -> 0x000080FF.
- Word load at 0x3001 -> adel=1, badvaddr=0x3001, req_ready=1, no bus_req; word store at 0x3002 -> ades=1.
- 5 stores with SB_DEPTH=4, gnt=0 -> 5th sees req_ready=0 until the first gnt, then is accepted; sb_count never exceeds 4.
- Store to 0x4000 buffered, then load 0x4002 -> req_ready=0 until the store is granted; load bus_req follows.
- Load in LD_WAIT, flush=1, then rvalid -> no resp_valid; reset asserted in ST_REQ -> bus_req=0 and sb_count=0 next cycle.
